mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Load/store unit bridge: accepts one core memory request at a time and
// executes it as a single Avalon-MM read or write. Misaligned or
// illegal-size requests are rejected without touching the bus. Bus accesses
// that stall longer than MAX_WAIT cycles are abandoned with an error.
//
// Ports
//   clk, reset        : system clock, synchronous active-high reset
//   req_valid/ready   : request handshake (ready only while idle)
//   req_write         : 1 = store, 0 = load
//   req_size          : 0 = byte, 1 = halfword, 2 = word, 3 = illegal
//   req_signed        : load sign-extension select
//   req_addr          : byte address
//   req_wdata         : right-justified store data
//   resp_valid        : one-cycle completion pulse
//   resp_rdata        : extended load data (0 for stores and errors)
//   resp_err          : misaligned, illegal size or bus timeout
//   avm_*             : Avalon-MM master
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata
);

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               write_q;
  logic               signed_q;
  logic [1:0]         size_q;
  logic [1:0]         lane_q;

  function automatic logic bad_request(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return lo[0];
      2'd2:    return (lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    return 4'b0001 << lo;
      2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data shifted into its lane(s); every other bit forced to zero.
  function automatic logic [31:0] place_store(input logic [1:0] size, input logic [1:0] lo,
                                              input logic [31:0] wdata);
    case (size)
      2'd0:    return {24'd0, wdata[7:0]} << {lo, 3'b000};
      2'd1:    return {16'd0, wdata[15:0]} << {lo[1], 4'b0000};
      default: return wdata;
    endcase
  endfunction

  // Bring the addressed lane(s) down to bit 0, then extend.
  function automatic logic [31:0] extract_load(input logic [1:0] size, input logic [1:0] lo,
                                               input logic sgn, input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {lo, 3'b000};
    case (size)
      2'd0:    return sgn ? {{24{sh[7]}}, sh[7:0]}   : {24'd0, sh[7:0]};
      2'd1:    return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      write_q        <= 1'b0;
      signed_q       <= 1'b0;
      size_q         <= 2'd0;
      lane_q         <= 2'd0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_err       <= 1'b0;
      resp_rdata     <= '0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          if (req_valid) begin
            write_q   <= req_write;
            signed_q  <= req_signed;
            size_q    <= req_size;
            lane_q    <= req_addr[1:0];
            req_ready <= 1'b0;
            if (bad_request(req_size, req_addr[1:0])) begin
              // Rejected locally: straight to the response pulse, bus untouched.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state          <= BUS;
              wait_cnt       <= '0;
              avm_address    <= {req_addr[31:2], 2'b00};
              avm_byteenable <= lane_mask(req_size, req_addr[1:0]);
              avm_writedata  <= req_write ? place_store(req_size, req_addr[1:0], req_wdata) : '0;
              avm_read       <= ~req_write;
              avm_write      <= req_write;
            end
          end
        end

        BUS: begin
          if (!avm_waitrequest) begin
            avm_read   <= 1'b0;
            avm_write  <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= write_q ? '0 : extract_load(size_q, lane_q, signed_q, avm_readdata);
          end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            // This edge completes the MAX_WAIT-th stalled cycle: give up.
            avm_read   <= 1'b0;
            avm_write  <= 1'b0;
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          avm_read  <= 1'b0;
          avm_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed and randomized load/store traffic against mem_access_ctrl with
// MAX_WAIT = 4. Expected bus fields, latency and response data come from a
// arithmetic reference model of the lane/extension rules.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  int errors = 0;
  int checks = 0;

  mem_access_ctrl #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read and write strobes must never be high together.
  always @(negedge clk) begin
    checks++;
    assert (!(avm_read === 1'b1 && avm_write === 1'b1)) else begin
      errors++;
      $display("FAIL strobe_overlap observed=%b%b expected=not 11", avm_read, avm_write);
      $error("strobe overlap");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_bad(input logic [1:0] sz, input logic [31:0] a);
    int lane = a % 4;
    if (sz == 3) return 1;
    if (sz == 1) return (lane % 2) != 0;
    if (sz == 2) return lane != 0;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int lane = a % 4;
    if (sz == 0) return 4'(1 << lane);
    if (sz == 1) return (lane == 0) ? 4'd3 : 4'd12;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] a,
                                       input logic [31:0] wd);
    longint unsigned lane = a % 4;
    longint unsigned scale = 64'd1 << (8 * lane);
    if (sz == 0) return 32'((longint'(wd) % 256) * scale);
    if (sz == 1) return 32'((longint'(wd) % 65536) * scale);
    return wd;
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] sz, input logic sg,
                                       input logic [31:0] a, input logic [31:0] rd);
    longint lane = a % 4;
    longint v = longint'(rd) / (64'sd1 << (8 * lane));
    if (sz == 0) begin
      v = v % 256;
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 1) begin
      v = v % 65536;
      if (sg && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(rd);
    end
    return 32'(v);
  endfunction

  // One complete transaction starting in an idle cycle (posedge+1).
  task automatic txn(input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] rd, input int nwait);
    bit          bad;
    bit          done;
    bit          exp_err;
    int          k;
    int          strobes;
    int          exp_strobes;
    logic [31:0] exp_rdata;
    bad = m_bad(sz, addr);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    tick();
    // Scramble request fields: the controller must have latched them.
    req_valid = 1'b0; req_write = $urandom; req_size = $urandom; req_signed = $urandom;
    req_addr = $urandom; req_wdata = $urandom;
    check("ready_busy", {31'd0, req_ready}, 32'd0);
    if (bad) begin
      check("bad_strobes", {30'd0, avm_read, avm_write}, 32'd0);
      check("bad_valid", {31'd0, resp_valid}, 32'd1);
      check("bad_err", {31'd0, resp_err}, 32'd1);
      check("bad_rdata", resp_rdata, 32'd0);
    end else begin
      k = 0; done = 0; strobes = 0; exp_err = 0;
      exp_strobes = (nwait + 1 < MW) ? nwait + 1 : MW;
      while (!done) begin
        check("strobe_rd", {31'd0, avm_read}, {31'd0, ~wr});
        check("strobe_wr", {31'd0, avm_write}, {31'd0, wr});
        check("address", avm_address, {addr[31:2], 2'b00});
        check("byteenable", {28'd0, avm_byteenable}, {28'd0, m_be(sz, addr)});
        if (wr) check("writedata", avm_writedata, m_wd(sz, addr, wd));
        check("no_early_resp", {31'd0, resp_valid}, 32'd0);
        avm_waitrequest = (k < nwait);
        avm_readdata = (k < nwait) ? $urandom : rd;
        tick();
        strobes++;
        if (k >= nwait) done = 1;
        else if (k + 1 == MW) begin done = 1; exp_err = 1; end
        k++;
      end
      avm_waitrequest = 1'b0;
      avm_readdata = $urandom;
      exp_rdata = (wr || exp_err) ? 32'd0 : m_rd(sz, sg, addr, rd);
      check("strobe_cycles", strobes, exp_strobes);
      check("strobes_low", {30'd0, avm_read, avm_write}, 32'd0);
      check("resp_valid", {31'd0, resp_valid}, 32'd1);
      check("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
      check("resp_rdata", resp_rdata, exp_rdata);
    end
    tick();
    check("resp_done", {31'd0, resp_valid}, 32'd0);
    check("ready_again", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h1234_5678; req_wdata = 32'hDEAD_BEEF;
    avm_waitrequest = 1'b0; avm_readdata = 32'hFFFF_FFFF;
    tick(); tick();
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_strobes", {30'd0, avm_read, avm_write}, 32'd0);
    check("rst_address", avm_address, 32'd0);
    check("rst_be", {28'd0, avm_byteenable}, 32'd0);
    check("rst_wdata", avm_writedata, 32'd0);
    req_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Store byte, lane 2, no wait.
    txn(1'b1, 2'd0, 1'b0, 32'h0000_1002, 32'h1234_5678, 32'h0, 0);
    // Signed halfword load, lane 2, three wait cycles.
    txn(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_FFFF, 3);
    // Misaligned word load.
    txn(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0, 32'h0, 0);
    // Illegal size.
    txn(1'b0, 2'd3, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 0);
    // Stuck waitrequest: timeout after MW wait cycles.
    txn(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 32'h1111_2222, 100);
    // Byte load signed/unsigned of 0x80.
    txn(1'b0, 2'd0, 1'b1, 32'h0000_4003, 32'h0, 32'h8000_0000, 0);
    txn(1'b0, 2'd0, 1'b0, 32'h0000_4003, 32'h0, 32'h8000_0000, 1);

    // Reset in the second BUS cycle of a store.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h0000_5000; req_wdata = 32'hCAFE_F00D;
    tick();
    req_valid = 1'b0;
    avm_waitrequest = 1'b1;
    tick();
    check("mid_write_high", {31'd0, avm_write}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    check("abort_write", {31'd0, avm_write}, 32'd0);
    check("abort_valid", {31'd0, resp_valid}, 32'd0);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_addr", avm_address, 32'd0);
    tick();
    check("abort_no_resp", {31'd0, resp_valid}, 32'd0);

    // Back-to-back with req_valid held high.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0000_6000;
    avm_readdata = 32'h0BAD_F00D;
    tick();
    check("b2b_read", {30'd0, avm_read, avm_write}, 32'd2);
    tick();
    check("b2b_resp1", {31'd0, resp_valid}, 32'd1);
    check("b2b_rdata1", resp_rdata, 32'h0BAD_F00D);
    check("b2b_ready_resp", {31'd0, req_ready}, 32'd0);
    req_write = 1'b1; req_addr = 32'h0000_6004; req_wdata = 32'h0102_0304;
    tick();
    check("b2b_idle_gap", {30'd0, avm_read, avm_write}, 32'd0);
    check("b2b_ready_idle", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check("b2b_write", {30'd0, avm_read, avm_write}, 32'd1);
    check("b2b_wdata", avm_writedata, 32'h0102_0304);
    tick();
    check("b2b_resp2", {31'd0, resp_valid}, 32'd1);
    tick();

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 1) a[0] = 1'b0;
        if (sz == 2) a[1:0] = 2'b00;
      end
      txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, $urandom_range(0, 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
